// File: rtl/trace_capture_ctrl.sv
// Snoops peripheral-bus writes into a small record buffer.
// Records, filters and status are read back through a CSR slave port.
module trace_capture_ctrl #(
  parameter int DEPTH    = 4,
  parameter int TS_WIDTH = 32
) (
  input  logic        clk_i,
  input  logic        arst_n_i,
  input  logic        snoop_req_i,
  input  logic        snoop_ack_i,
  input  logic        snoop_we_i,
  input  logic [31:0] snoop_addr_i,
  input  logic [3:0]  snoop_be_i,
  input  logic [31:0] snoop_wdata_i,
  input  logic        csr_req_i,
  input  logic        csr_we_i,
  input  logic [7:0]  csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic        csr_resp_o,
  output logic [31:0] csr_rdata_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_C = 8'(DEPTH);
  localparam logic [4:0] DEPTH_S = 5'(DEPTH);
  localparam logic [3:0] LAST = 4'(DEPTH - 1);

  logic                en;
  logic                wrap;
  logic [31:0]         base;
  logic [31:0]         mask;
  logic [TS_WIDTH-1:0] ts;
  logic [31:0]         ts_ext;
  logic [23:0]         seq;
  logic [3:0]          wr_ptr;
  logic [7:0]          count;
  logic                ovf;

  logic [31:0] rec_ts   [DEPTH];
  logic [31:0] rec_addr [DEPTH];
  logic [31:0] rec_data [DEPTH];
  logic [3:0]  rec_be   [DEPTH];
  logic [23:0] rec_seq  [DEPTH];

  logic [5:0]    off;
  logic          csr_wr;
  logic          clr;
  logic          full;
  logic          hit;
  logic          store;
  logic [3:0]    rec_n;
  logic [4:0]    slot;
  logic [AW-1:0] sidx;
  logic          rec_ok;
  logic [31:0]   rd_val;
  logic          unused_bits;

  assign off    = csr_addr_i[7:2];
  assign csr_wr = csr_req_i & csr_we_i;
  assign clr    = csr_wr && off == 6'h00 && csr_wdata_i[2];
  assign full   = count == DEPTH_C;
  assign ts_ext = 32'(ts);
  assign hit    = snoop_req_i & snoop_ack_i & snoop_we_i & en &
                  ((snoop_addr_i & mask) == (base & mask));
  // A full buffer only accepts the hit when wrapping; CLR always wins.
  assign store  = hit & ~clr & (~full | wrap);
  assign unused_bits = ^csr_addr_i[1:0];

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      en   <= 1'b0;
      wrap <= 1'b0;
      base <= '0;
      mask <= '0;
    end else if (csr_wr) begin
      unique case (1'b1)
        off == 6'h00: begin
          en   <= csr_wdata_i[0];
          wrap <= csr_wdata_i[1];
        end
        off == 6'h04: base <= csr_wdata_i;
        off == 6'h05: mask <= csr_wdata_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) ts <= '0;
    else           ts <= ts + 1'b1;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      seq    <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (clr) begin
      seq    <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (hit) begin
      if (full) ovf <= 1'b1;
      if (store) begin
        seq    <= seq + 24'd1;
        wr_ptr <= (wr_ptr == LAST) ? 4'd0 : wr_ptr + 4'd1;
        if (!full) count <= count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) begin
      rec_ts[wr_ptr[AW-1:0]]   <= ts_ext;
      rec_addr[wr_ptr[AW-1:0]] <= snoop_addr_i;
      rec_data[wr_ptr[AW-1:0]] <= snoop_wdata_i;
      rec_be[wr_ptr[AW-1:0]]   <= snoop_be_i;
      rec_seq[wr_ptr[AW-1:0]]  <= seq;
    end
  end

  // Logical record n maps to the oldest slot when the ring is full.
  always_comb begin
    rd_val = '0;
    rec_n  = csr_addr_i[7:4] - 4'd4;
    slot   = {1'b0, full ? wr_ptr : 4'd0} + {1'b0, rec_n};
    if (slot >= DEPTH_S) slot = slot - DEPTH_S;
    sidx   = slot[AW-1:0];
    rec_ok = (csr_addr_i[7:6] != 2'b00) && ({4'b0, rec_n} < count);
    unique case (1'b1)
      rec_ok: begin
        unique case (csr_addr_i[3:2])
          2'd0: rd_val = rec_ts[sidx];
          2'd1: rd_val = rec_addr[sidx];
          2'd2: rd_val = rec_data[sidx];
          default: rd_val = {4'b0, rec_be[sidx], rec_seq[sidx]};
        endcase
      end
      off == 6'h00: rd_val = {30'b0, wrap, en};
      off == 6'h01: rd_val = {12'b0, wr_ptr, 6'b0, ovf, full, count};
      off == 6'h02: rd_val = ts_ext;
      off == 6'h04: rd_val = base;
      off == 6'h05: rd_val = mask;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      csr_resp_o  <= 1'b0;
      csr_rdata_o <= '0;
    end else begin
      csr_resp_o  <= csr_req_i;
      csr_rdata_o <= (csr_req_i && !csr_we_i) ? rd_val : 32'd0;
    end
  end

endmodule

// File: doc/trace_capture_ctrl.md
Name: trace_capture_ctrl

Overview:
Memory-mapped controller that snoops the SoC peripheral bus and records qualifying write transactions into a small record buffer. Each record holds a timestamp, address, data and byte enables. The records are read back over a CSR slave port, normally by the UDM debug master.
The block sits beside the peripheral interconnect. Address decode is external; the block sees only an 8-bit local offset.

Parameters:
DEPTH, 4, number of record slots (1..12; window 0x40-0xFF limits it).
TS_WIDTH, 32, free-running timestamp counter width (≤32, zero-extended on read).

Ports:
clk_i  in  1  system clock
arst_n_i  in  1  reset, asynchronous assert, active low
snoop_req_i  in  1  bus request
snoop_ack_i  in  1  bus grant/accept; a transfer occurs when req&ack
snoop_we_i  in  1  write enable
snoop_addr_i  in  32  bus address
snoop_be_i  in  4  byte enables
snoop_wdata_i  in  32  write data
csr_req_i  in  1  CSR access request
csr_we_i  in  1  CSR write
csr_addr_i  in  8  byte offset (bits [1:0] ignored)
csr_wdata_i  in  32  CSR write data
csr_resp_o  out  1  one-cycle response pulse
csr_rdata_o  out  32  read data, valid with csr_resp_o

Behaviour:
Reset (arst_n_i=0, any time, including mid-capture):
- csr_resp_o=0, csr_rdata_o=0.
- CTRL=0, FILTER_BASE=0, FILTER_MASK=0.
- Timestamp, seq, wr_ptr, count and overflow = 0.
- Record contents need not be cleared.

CSR map (all accesses 32-bit):
- 0x00 CTRL rw: bit0 EN, bit1 WRAP, bit2 CLR (write-1 pulse, reads 0).
- 0x04 STATUS ro: [7:0] count, [8] full, [9] overflow (sticky), [19:16] wr_ptr.
- 0x08 TIMESTAMP ro.
- 0x10 FILTER_BASE rw.
- 0x14 FILTER_MASK rw.
- 0x40+16*n+4*k: record n, word k. k0 = timestamp, k1 = addr, k2 = wdata, k3 = {be[3:0] at [27:24], seq[23:0]}.
- Unmapped offsets read 0; writes to them are ignored.

CSR handshake:
- A request in cycle T gives csr_resp_o=1 in T+1; rdata is registered at T.
- Back-to-back requests are accepted every cycle.
- A write takes effect at the T edge and is visible to a read issued at T+1.

Capture:
- Hit = snoop_req_i & snoop_ack_i & snoop_we_i & EN & ((snoop_addr_i & MASK) == (BASE & MASK)).
- Reads on the snooped bus are never captured.
- On a hit in cycle T, the slot at wr_ptr is written at the T edge with the timestamp value of cycle T. seq increments (24-bit, wraps).
- wr_ptr increments modulo DEPTH.
- count saturates at DEPTH; full = (count==DEPTH).
- At most one capture per cycle.

Full handling:
- WRAP=0: hit is dropped, overflow set, seq unchanged.
- WRAP=1: oldest record is overwritten, overflow set, seq increments.

Read ordering:
- Record index n is logical, oldest first: slot = (base + n) mod DEPTH, where base = full ? wr_ptr : 0.
- Reads with n ≥ count return 0.

CLR:
- Zeroes count, wr_ptr, overflow and seq.
- Timestamp and filters are not affected.
- CLR in the same cycle as a hit: CLR wins and the hit is discarded.

Other simultaneous and boundary cases:
- CSR read of a record in the same cycle it is written returns the old contents.
- The timestamp increments every cycle, including when EN=0, and wraps at 2^TS_WIDTH.
- EN cleared mid-stream: hits stop from the next cycle. Stored records are kept.

Test Plan:
1. Reset then read 0x00, 0x04, 0x40 -> all 0. csr_resp_o is exactly one cycle after each req.
2. Setup: BASE=0x00100000, MASK=0xFFFFFF00, EN=1. Writes 0x00100004←0x00111111, 0x00100010←0x00222222, 0x00200000←0x5 -> count=2. Record0 = {addr 0x00100004, data 0x00111111, seq 0}; record1 has seq 1. The 0x00200000 write is not captured. Record1 timestamp minus record0 timestamp equals the cycle gap.
3. DEPTH=4, WRAP=0: 6 hits -> count=4, full=1, overflow=1. Records hold only the first 4 data values. Reading n=0..3 gives the first 4 in order.
4. DEPTH=4, WRAP=1: 6 hits with data 1..6 -> records n=0..3 = 3,4,5,6; seq 2..5; wr_ptr=2.
5. CLR written in the same cycle as a hit -> count=0, overflow=0. The next hit lands in record0 with seq 0.
6. Assert arst_n_i for 1 cycle between two hits, with a CSR read outstanding -> no csr_resp_o pulse, all status 0. The post-reset hit is dropped because EN=0.
